// File: rtl/cargador_serial_if.sv
// Operand-loader bus: serial operand input, network feedback and result handshake.
interface cargador_serial_if #(
  parameter int K = 4
);
  logic         inicio;
  logic         A_ser;
  logic         B_ser;
  logic         bit_valido;
  logic         Z_red;
  logic         acepta;
  logic [K-1:0] A;
  logic [K-1:0] B;
  logic         Z;
  logic         valido;
  logic         listo;

  modport master (
    output inicio, A_ser, B_ser, bit_valido, Z_red, acepta,
    input  A, B, Z, valido, listo
  );

  modport slave (
    input  inicio, A_ser, B_ser, bit_valido, Z_red, acepta,
    output A, B, Z, valido, listo
  );
endinterface

// File: rtl/cargador_serial.sv
// Serial loader for an operand pair feeding an iterative comparator network;
// captures the network result one cycle after loading and holds it until taken.
module cargador_serial #(
  parameter int K = 4
) (
  input  logic              clk,
  input  logic              reset,
  cargador_serial_if.slave  bus
);
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CARGA   = 2'b01,
    EVALUA  = 2'b10,
    ENTREGA = 2'b11
  } estado_t;

  estado_t         state_r, state_s;
  logic [K-1:0]    a_r, a_s;
  logic [K-1:0]    b_r, b_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            z_r, z_s;
  logic            valido_r, valido_s;
  logic            listo_r;

  // Next-state and datapath next values
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    cnt_s    = cnt_r;
    z_s      = z_r;
    valido_s = valido_r;
    case (state_r)
      REPOSO: begin
        if (bus.inicio) begin
          state_s = CARGA;
          a_s     = {K{1'b0}};
          b_s     = {K{1'b0}};
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = REPOSO;
        end
      end
      CARGA: begin
        if (bus.bit_valido) begin
          a_s = {a_r[K-2:0], bus.A_ser};
          b_s = {b_r[K-2:0], bus.B_ser};
          // Last bit: counter wraps so the next load starts from zero anyway
          if (cnt_r == CW'(K - 1)) begin
            cnt_s   = {CW{1'b0}};
            state_s = EVALUA;
          end else begin
            cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = CARGA;
        end
      end
      EVALUA: begin
        z_s      = bus.Z_red;
        valido_s = 1'b1;
        state_s  = ENTREGA;
      end
      ENTREGA: begin
        if (bus.acepta) begin
          valido_s = 1'b0;
          state_s  = REPOSO;
        end else begin
          state_s  = ENTREGA;
        end
      end
      default: begin
        state_s  = REPOSO;
        valido_s = 1'b0;
      end
    endcase
  end

  // State and output registers; listo tracks the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= REPOSO;
      a_r      <= {K{1'b0}};
      b_r      <= {K{1'b0}};
      cnt_r    <= {CW{1'b0}};
      z_r      <= 1'b0;
      valido_r <= 1'b0;
      listo_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      cnt_r    <= cnt_s;
      z_r      <= z_s;
      valido_r <= valido_s;
      listo_r  <= (state_s == REPOSO);
    end
  end

  assign bus.A      = a_r;
  assign bus.B      = b_r;
  assign bus.Z      = z_r;
  assign bus.valido = valido_r;
  assign bus.listo  = listo_r;
endmodule

// File: tb/tb_cargador_serial.sv
// Directed bench for cargador_serial: transaction-level model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_cargador_serial;
  localparam int K = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  bit   chk_en;

  cargador_serial_if #(.K(K)) bus ();

  cargador_serial #(.K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an operand pair is "being loaded" while bits remain, then one
  // evaluation cycle, then the result is held until taken.
  int m_left;
  bit m_eval;
  bit m_hold;
  int m_a;
  int m_b;
  bit m_z;
  bit m_valid;

  initial begin
    m_left = 0; m_eval = 0; m_hold = 0;
    m_a = 0; m_b = 0; m_z = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_eval = 0; m_hold = 0;
      m_a = 0; m_b = 0; m_z = 0; m_valid = 0;
    end else if (m_hold) begin
      if (bus.acepta) begin
        m_hold  = 0;
        m_valid = 0;
      end
    end else if (m_eval) begin
      m_z     = bus.Z_red;
      m_valid = 1;
      m_eval  = 0;
      m_hold  = 1;
    end else if (m_left > 0) begin
      if (bus.bit_valido) begin
        m_a    = (m_a * 2 + int'(bus.A_ser)) % (1 << K);
        m_b    = (m_b * 2 + int'(bus.B_ser)) % (1 << K);
        m_left = m_left - 1;
        if (m_left == 0) m_eval = 1;
      end
    end else if (bus.inicio) begin
      m_a = 0;
      m_b = 0;
      m_left = K;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("A_vs_model", int'(bus.A), m_a);
      check("B_vs_model", int'(bus.B), m_b);
      check("Z_vs_model", int'(bus.Z), int'(m_z));
      check("valido_vs_model", int'(bus.valido), int'(m_valid));
      check("listo_vs_model", int'(bus.listo),
            int'(!(m_hold || m_eval || (m_left > 0))));
    end
  end

  task automatic apply(input logic ini, input logic a, input logic b,
                       input logic bv, input logic zr, input logic ac);
    reset          = 1'b0;
    bus.inicio     = ini;
    bus.A_ser      = a;
    bus.B_ser      = b;
    bus.bit_valido = bv;
    bus.Z_red      = zr;
    bus.acepta     = ac;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.inicio     = 1'b1;
    bus.bit_valido = 1'b1;
    bus.acepta     = 1'b1;
    bus.A_ser      = 1'b1;
    bus.B_ser      = 1'b1;
    bus.Z_red      = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // inicio, K bits MSB first, then the evaluation cycle with zr on Z_red
  task automatic load(input logic [K-1:0] av, input logic [K-1:0] bv, input logic zr);
    apply(1'b1, 1'b0, 1'b0, 1'b0, ~zr, 1'b0);
    for (int i = K - 1; i >= 0; i--) apply(1'b0, av[i], bv[i], 1'b1, ~zr, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, zr, 1'b0);
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, "_A"}, int'(bus.A), 0);
    check({tag, "_B"}, int'(bus.B), 0);
    check({tag, "_Z"}, int'(bus.Z), 0);
    check({tag, "_valido"}, int'(bus.valido), 0);
    check({tag, "_listo"}, int'(bus.listo), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    reset = 1'b1;
    bus.inicio = 1'b0; bus.A_ser = 1'b0; bus.B_ser = 1'b0;
    bus.bit_valido = 1'b0; bus.Z_red = 1'b0; bus.acepta = 1'b0;
    @(posedge clk); #2;
    do_reset();
    chk_en = 1;
    check_idle_clear("reset");

    // Basic load, continuous bits: valido rises after edge t0+K+1
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("listo_in_carga", int'(bus.listo), 0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("valido_t0p4", int'(bus.valido), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("valido_t0p5", int'(bus.valido), 1);
    check("basic_A", int'(bus.A), 4'b1011);
    check("basic_B", int'(bus.B), 4'b0110);
    check("basic_Z", int'(bus.Z), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("accept_valido", int'(bus.valido), 0);
    check("accept_listo", int'(bus.listo), 1);
    check("accept_Z_kept", int'(bus.Z), 1);

    // Two stall cycles between bits 2 and 3; Z_red toggled outside EVALUA
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall_valido_t0p5", int'(bus.valido), 0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_valido_t0p6", int'(bus.valido), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_valido_t0p7", int'(bus.valido), 1);
    check("stall_A", int'(bus.A), 4'b1011);
    check("stall_B", int'(bus.B), 4'b0110);
    check("stall_Z", int'(bus.Z), 1);

    // Consumer back-pressure: result held while acepta low, inicio ignored
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("hold_valido", int'(bus.valido), 1);
      check("hold_Z", int'(bus.Z), 1);
      check("hold_A", int'(bus.A), 4'b1011);
      check("hold_B", int'(bus.B), 4'b0110);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_release_listo", int'(bus.listo), 1);
    check("hold_release_valido", int'(bus.valido), 0);

    // acepta while idle has no effect
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_acepta_listo", int'(bus.listo), 1);
    check("idle_acepta_A", int'(bus.A), 4'b1011);

    // inicio re-asserted mid-load does not restart
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_A", int'(bus.A), 4'b0111);
    check("restart_B", int'(bus.B), 4'b1100);
    check("restart_Z", int'(bus.Z), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset with a pending result, then reset mid-load, then a clean load
    load(4'b1111, 4'b0000, 1'b1);
    check("pending_Z", int'(bus.Z), 1);
    do_reset();
    check_idle_clear("rst_entrega");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    check_idle_clear("rst_carga");
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_no_valido", int'(bus.valido), 0);
    load(4'b1010, 4'b0101, 1'b1);
    check("clean_A", int'(bus.A), 4'b1010);
    check("clean_B", int'(bus.B), 4'b0101);
    check("clean_Z", int'(bus.Z), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: accept then immediate inicio for a new pair
    load(4'b1011, 4'b0110, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_clear_A", int'(bus.A), 0);
    check("b2b_clear_B", int'(bus.B), 0);
    for (int i = 0; i < K; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_A", int'(bus.A), 4'b0000);
    check("b2b_B", int'(bus.B), 4'b1111);
    check("b2b_Z", int'(bus.Z), 0);
    check("b2b_valido", int'(bus.valido), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cargador_serial.md
CARGADOR_SERIAL -- requirements
Module: cargador_serial

Interface
REQ-001 Parameter K, default 4, SHALL set operand word width in bits; legal range K >= 2.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 Port inicio  input  1  SHALL request loading of a new operand pair.
REQ-005 Port A_ser  input  1  SHALL carry serial operand A bits, MSB first (left to right).
REQ-006 Port B_ser  input  1  SHALL carry serial operand B bits, MSB first, aligned with A_ser.
REQ-007 Port bit_valido  input  1  SHALL qualify A_ser/B_ser as valid in the current cycle.
REQ-008 Port Z_red  input  1  SHALL receive the combinational result Z of the downstream iterative comparator network.
REQ-009 Port acepta  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-010 Port A  output  K  SHALL drive operand A to the iterative network.
REQ-011 Port B  output  K  SHALL drive operand B to the iterative network.
REQ-012 Port Z  output  1  SHALL hold the registered network result.
REQ-013 Port valido  output  1  SHALL flag Z as a valid, unconsumed result.
REQ-014 Port listo  output  1  SHALL be high only in state REPOSO.

Function
REQ-015 FSM SHALL have states REPOSO, CARGA, EVALUA, ENTREGA, fully encoded; illegal encodings go to REPOSO next cycle.
REQ-016 REPOSO: inicio=1 -> CARGA; A, B, bit counter cleared to 0 on that edge; Z retains previous value.
REQ-017 CARGA: each edge with bit_valido=1 SHALL shift A <= {A[K-2:0], A_ser}, B <= {B[K-2:0], B_ser}, counter +1.
REQ-018 CARGA: bit_valido=0 SHALL hold A, B, counter unchanged (stall, no timeout).
REQ-019 Counter width clog2(K); when counter = K-1 and bit_valido=1, the K-th bit is shifted and state -> EVALUA; counter wraps to 0.
REQ-020 inicio asserted in CARGA, EVALUA or ENTREGA SHALL be ignored (no restart, no queuing).
REQ-021 EVALUA lasts exactly one cycle; A, B stable; on its exit edge Z <= Z_red, valido <= 1, state -> ENTREGA.
REQ-022 ENTREGA: valido=1, Z, A, B held stable until acepta=1.
REQ-023 ENTREGA with acepta=1: valido <= 0, state -> REPOSO on that edge; A, B, Z retained.
REQ-024 acepta outside ENTREGA SHALL have no effect.
REQ-025 Latency with continuous bit_valido: inicio sampled at edge t0 -> valido high after edge t0+K+1.
REQ-026 A and B outputs SHALL change only in CARGA or on the REPOSO->CARGA edge.
REQ-027 Z_red SHALL be sampled only on the EVALUA exit edge; its value in all other states is ignored.

Reset
REQ-028 reset=1 SHALL, on the next rising edge, force state REPOSO, A=0, B=0, counter=0, Z=0, valido=0, listo=1.
REQ-029 reset SHALL take priority over inicio, bit_valido and acepta in the same cycle.
REQ-030 reset mid-CARGA or mid-ENTREGA SHALL discard partial operand and pending result with no valido pulse.

Verification
REQ-031 K=4, inicio, then A_ser 1,0,1,1 / B_ser 0,1,1,0 on 4 consecutive cycles, Z_red=1 -> A=1011, B=0110, Z=1, valido high after edge t0+5.
REQ-032 Same stimulus with bit_valido=0 for 2 cycles between bits 2 and 3 -> identical A/B/Z, valido delayed by exactly 2 cycles.
REQ-033 acepta held 0 for 3 cycles in ENTREGA, then 1 -> valido, Z, A, B stable 4 cycles, listo=1 the cycle after acepta.
REQ-034 inicio pulsed during CARGA after 2 bits -> load not restarted; final A/B reflect all 4 original bits.
REQ-035 reset asserted after 3 bits loaded -> next cycle A=0000, B=0000, Z=0, valido=0, listo=1; subsequent inicio loads cleanly.
REQ-036 Back-to-back: acepta and inicio in consecutive cycles, second pair A=0000/B=1111 with Z_red=0 -> Z=0, no stale bits from first pair.
